// File: rtl/shifter_pkg.sv
// Shared encodings for the bit-serial barrel-shift sequencer: shift types,
// FSM states and the decode of (Imm, Type, Amount) into an effective plan.
package shifter_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int COUNT_BITS  = 6;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic [COUNT_BITS-1:0] count;
    logic                  zeroData;
    logic                  rrx;
    logic                  carryFromMsb;
  } shift_plan_t;

  // Out-of-range LSL/LSR still run 32 steps, but on zeroed data so both
  // the result and the final carry come out as zero.
  function automatic shift_plan_t planShift(input logic        imm,
                                            input shift_type_e typ,
                                            input logic [7:0]  amount);
    shift_plan_t plan;
    plan = '0;
    if (imm) begin
      if (amount[4:0] != 5'd0) begin
        plan.count = {1'b0, amount[4:0]};
      end else begin
        case (typ)
          SH_LSL: plan.count = COUNT_BITS'(0);
          SH_LSR: plan.count = COUNT_BITS'(32);
          SH_ASR: plan.count = COUNT_BITS'(32);
          SH_ROR: begin
            plan.count = COUNT_BITS'(1);
            plan.rrx   = 1'b1;
          end
        endcase
      end
    end else if (amount != 8'd0) begin
      if (typ == SH_ROR) begin
        plan.count        = {1'b0, amount[4:0]};
        plan.carryFromMsb = (amount[4:0] == 5'd0);
      end else if (amount >= 8'd32) begin
        plan.count    = COUNT_BITS'(32);
        plan.zeroData = (typ != SH_ASR) && (amount != 8'd32);
      end else begin
        plan.count = {1'b0, amount[4:0]};
      end
    end
    return plan;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between a requester and the shift sequencer.
interface shift_sequencer_if #(parameter int WIDTH = 32);

  logic             Start;
  logic [WIDTH-1:0] Operand;
  logic [7:0]       Amount;
  logic [1:0]       Type;
  logic             Imm;
  logic             CIn;
  logic [WIDTH-1:0] Out;
  logic             Cout;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Operand, Amount, Type, Imm, CIn,
    input  Out, Cout, Busy, Done
  );

  modport slave (
    input  Start, Operand, Amount, Type, Imm, CIn,
    output Out, Cout, Busy, Done
  );

endinterface

// File: rtl/shift_step.sv
// One-position combinational shift: produces the next data word and the bit
// that fell out. RRX rotates the incoming carry into the top bit.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  shift_type_e      i_type,
  input  logic             i_rrx,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  always_comb begin
    o_data  = i_data;
    o_carry = i_carry;
    case (i_type)
      SH_LSL: begin
        o_data  = {i_data[WIDTH-2:0], 1'b0};
        o_carry = i_data[WIDTH-1];
      end
      SH_LSR: begin
        o_data  = {1'b0, i_data[WIDTH-1:1]};
        o_carry = i_data[0];
      end
      SH_ASR: begin
        o_data  = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
        o_carry = i_data[0];
      end
      SH_ROR: begin
        o_data  = {(i_rrx ? i_carry : i_data[0]), i_data[WIDTH-1:1]};
        o_carry = i_data[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: captures a request in IDLE, shifts one position per
// cycle, then pulses Done with the result held until the next accept.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               Clk,
  input logic               nReset,
  shift_sequencer_if.slave  bus
);

  seq_state_e            r_state;
  seq_state_e            w_nextState;
  logic [WIDTH-1:0]      r_data;
  logic                  r_carry;
  logic [COUNT_BITS-1:0] r_count;
  shift_type_e           r_type;
  logic                  r_rrx;

  shift_plan_t           w_plan;
  logic                  w_accept;
  logic [WIDTH-1:0]      w_stepData;
  logic                  w_stepCarry;
  logic                  w_busy;
  logic                  w_done;

  assign w_plan   = planShift(bus.Imm, shift_type_e'(bus.Type), bus.Amount);
  assign w_accept = (r_state == ST_IDLE) && bus.Start;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_type  (r_type),
    .i_rrx   (r_rrx),
    .i_data  (r_data),
    .i_carry (r_carry),
    .o_data  (w_stepData),
    .o_carry (w_stepCarry)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          w_nextState = (w_plan.count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (r_count == COUNT_BITS'(1)) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Everything the operation needs is latched at accept, so the request
  // inputs are free to change while the shift is in flight.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_data  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_type  <= SH_LSL;
      r_rrx   <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_plan.zeroData ? '0 : bus.Operand;
      r_carry <= w_plan.carryFromMsb ? bus.Operand[WIDTH-1] : bus.CIn;
      r_count <= w_plan.count;
      r_type  <= shift_type_e'(bus.Type);
      r_rrx   <= w_plan.rrx;
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_stepData;
      r_carry <= w_stepCarry;
      r_count <= r_count - COUNT_BITS'(1);
    end
  end

  assign bus.Out  = r_data;
  assign bus.Cout = r_carry;
  assign bus.Busy = w_busy;
  assign bus.Done = w_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_shift_sequencer;

  logic Clk;
  logic nReset;
  int   passCount  = 0;
  int   checkCount = 0;

  shift_sequencer_if #(.WIDTH(32)) bus ();

  shift_sequencer #(.WIDTH(32)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h",
                  name, $time, actual, expected);
  endtask

  // Result of a whole operation computed directly from the shift rules.
  function automatic void modelShift(input logic imm, input logic [1:0] typ,
                                     input logic [7:0] amount, input logic [31:0] op,
                                     input logic cin, output logic [31:0] out,
                                     output logic cout, output int lat);
    int          a;
    logic [63:0] wide;
    out  = op;
    cout = cin;
    lat  = 1;
    wide = (typ == 2'b10 && op[31]) ? {32'hFFFF_FFFF, op} : {32'h0, op};
    if (imm) begin
      a = int'(amount[4:0]);
      if (typ == 2'b00) begin
        if (a != 0) begin out = op << a; cout = op[32-a]; lat = a + 1; end
      end else if (typ == 2'b11) begin
        if (a == 0) begin out = {cin, op[31:1]}; cout = op[0]; lat = 2; end
        else begin out = (op >> a) | (op << (32 - a)); cout = op[a-1]; lat = a + 1; end
      end else begin
        if (a == 0) a = 32;
        out = 32'(wide >> a); cout = op[a-1]; lat = a + 1;
      end
    end else if (amount != 8'd0) begin
      a = int'(amount);
      if (typ == 2'b11) begin
        a = a % 32;
        if (a == 0) begin out = op; cout = op[31]; lat = 1; end
        else begin out = (op >> a) | (op << (32 - a)); cout = op[a-1]; lat = a + 1; end
      end else if (a < 32) begin
        if (typ == 2'b00) begin out = op << a; cout = op[32-a]; end
        else begin out = 32'(wide >> a); cout = op[a-1]; end
        lat = a + 1;
      end else begin
        lat = 33;
        if (typ == 2'b10) begin out = {32{op[31]}}; cout = op[31]; end
        else begin
          out  = 32'h0;
          cout = (a == 32) ? ((typ == 2'b00) ? op[0] : op[31]) : 1'b0;
        end
      end
    end
  endfunction

  bit          mBusy  = 0;
  bit          mDone  = 0;
  bit          mValid = 1;
  int          mLeft  = 0;
  logic [31:0] mOut   = '0;
  logic        mCout  = 1'b0;
  logic [31:0] pendOut;
  logic        pendCout;
  int          pendLat;

  // Cycle timeline of the model: Done lands lat-1 cycles after the accept
  // edge, then one idle-return cycle; Start is only honoured when idle.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mBusy = 0; mDone = 0; mValid = 1; mLeft = 0; mOut = '0; mCout = 1'b0;
    end else if (!mBusy) begin
      if (bus.Start === 1'b1) begin
        modelShift(bus.Imm, bus.Type, bus.Amount, bus.Operand, bus.CIn,
                   pendOut, pendCout, pendLat);
        mBusy  = 1;
        mLeft  = pendLat - 1;
        mDone  = (mLeft == 0);
        mValid = mDone;
        if (mDone) begin mOut = pendOut; mCout = pendCout; end
      end
    end else if (mDone) begin
      mBusy = 0;
      mDone = 0;
    end else begin
      mLeft--;
      mDone = (mLeft == 0);
      if (mDone) begin mValid = 1; mOut = pendOut; mCout = pendCout; end
    end
  end

  always @(negedge Clk) begin
    checkOutput("cycle busy", 32'(bus.Busy), 32'(mBusy));
    checkOutput("cycle done", 32'(bus.Done), 32'(mDone));
    if (mValid) begin
      checkOutput("cycle out", bus.Out, mOut);
      checkOutput("cycle cout", 32'(bus.Cout), 32'(mCout));
    end
  end

  task automatic applyStimulus(input string name, input logic imm, input logic [1:0] typ,
                               input logic [7:0] amt, input logic [31:0] op, input logic cin,
                               input logic [31:0] expOut, input logic expCout,
                               input int expLat, input bit disturb);
    int lat;
    lat = -1;
    @(negedge Clk);
    bus.Start = 1'b1; bus.Imm = imm; bus.Type = typ;
    bus.Amount = amt; bus.Operand = op; bus.CIn = cin;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0; bus.Operand = ~op; bus.Type = ~typ;
    bus.CIn = ~cin; bus.Amount = amt ^ 8'h5A;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin lat = c; break; end
      if (disturb && c == 2) begin
        bus.Start = 1'b1; bus.Imm = 1'b0; bus.Type = 2'b00;
        bus.Amount = 8'd3; bus.Operand = 32'hFFFF_FFFF; bus.CIn = 1'b1;
      end
      if (disturb && c == 5) bus.Start = 1'b0;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " out"}, bus.Out, expOut);
    checkOutput({name, " cout"}, 32'(bus.Cout), 32'(expCout));
  endtask

  initial begin
    bit sawDone;
    bus.Start = 1'b0; bus.Imm = 1'b0; bus.Type = 2'b00;
    bus.Amount = 8'd0; bus.Operand = 32'h0; bus.CIn = 1'b0;
    nReset = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset busy", 32'(bus.Busy), 32'h0);
    checkOutput("reset done", 32'(bus.Done), 32'h0);
    checkOutput("reset out", bus.Out, 32'h0);
    checkOutput("reset cout", 32'(bus.Cout), 32'h0);
    nReset = 1'b1;

    applyStimulus("imm lsl4", 1, 2'b00, 8'd4, 32'h8000_000F, 0, 32'h0000_00F0, 0, 5, 0);
    applyStimulus("imm rrx", 1, 2'b11, 8'd0, 32'h0000_0001, 1, 32'h8000_0000, 1, 2, 0);
    applyStimulus("reg asr40", 0, 2'b10, 8'd40, 32'h8000_0000, 0, 32'hFFFF_FFFF, 1, 33, 0);
    applyStimulus("reg lsr32", 0, 2'b01, 8'd32, 32'h8000_0000, 0, 32'h0, 1, 33, 0);
    for (int t = 0; t < 4; t++)
      applyStimulus("reg amount0", 0, 2'(t), 8'd0, 32'h1234_5678, 1, 32'h1234_5678, 1, 1, 0);
    applyStimulus("reg lsl33", 0, 2'b00, 8'd33, 32'hFFFF_FFFF, 1, 32'h0, 0, 33, 0);
    applyStimulus("reg lsl32", 0, 2'b00, 8'd32, 32'h0000_0001, 0, 32'h0, 1, 33, 0);
    applyStimulus("imm lsr0", 1, 2'b01, 8'd0, 32'h8000_0000, 0, 32'h0, 1, 33, 0);
    applyStimulus("imm asr0", 1, 2'b10, 8'd0, 32'h7FFF_FFFF, 1, 32'h0, 0, 33, 0);
    applyStimulus("reg ror64", 0, 2'b11, 8'd64, 32'h8000_0001, 0, 32'h8000_0001, 1, 1, 0);
    applyStimulus("reg ror36", 0, 2'b11, 8'd36, 32'h0000_00F1, 1, 32'h1000_000F, 0, 5, 0);
    applyStimulus("imm lsl0", 1, 2'b00, 8'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 1, 0);
    applyStimulus("imm asr4", 1, 2'b10, 8'd4, 32'h8000_0010, 0, 32'hF800_0001, 0, 5, 0);
    applyStimulus("imm lsr3 hi bits", 1, 2'b01, 8'hE3, 32'h0000_000F, 0, 32'h0000_0001, 1, 4, 0);

    applyStimulus("busy ignore", 1, 2'b01, 8'd8, 32'h0000_0180, 0, 32'h0000_0001, 1, 9, 1);
    applyStimulus("back to back", 1, 2'b00, 8'd1, 32'h0000_0001, 1, 32'h0000_0002, 0, 2, 0);

    @(negedge Clk);
    bus.Start = 1'b1; bus.Imm = 1'b0; bus.Type = 2'b00;
    bus.Amount = 8'd20; bus.Operand = 32'hFFFF_FFFF; bus.CIn = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(bus.Busy), 32'h0);
    checkOutput("async reset done", 32'(bus.Done), 32'h0);
    checkOutput("async reset out", bus.Out, 32'h0);
    checkOutput("async reset cout", 32'(bus.Cout), 32'h0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    sawDone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) sawDone = 1;
    end
    checkOutput("no done after reset", 32'(sawDone), 32'h0);
    applyStimulus("post reset lsr1", 1, 2'b01, 8'd1, 32'h0000_0002, 0, 32'h0000_0001, 0, 2, 0);

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width; only 32 is supported.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1, request strobe, sampled only in IDLE.
REQ-005 SHALL have port Operand, input, 32, value to shift, captured on accepted Start.
REQ-006 SHALL have port Amount, input, 8, shift amount: the immediate value in bits [4:0] when Imm=1, the register bottom byte when Imm=0.
REQ-007 SHALL have port Type, input, 2, shift type: LSL=00, LSR=01, ASR=10, ROR=11.
REQ-008 SHALL have port Imm, input, 1, 1 = immediate-specified shift, 0 = register-specified shift.
REQ-009 SHALL have port CIn, input, 1, current C flag, captured on accepted Start.
REQ-010 SHALL have port Out, output, 32, shifted result, valid while Done=1 and held until the next accept.
REQ-011 SHALL have port Cout, output, 1, shifter carry-out, qualified the same way as Out.
REQ-012 SHALL have port Busy, output, 1, high from the accept cycle through the Done cycle.
REQ-013 SHALL have port Done, output, 1, single-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE: IDLE->SHIFT on Start with N>0; IDLE->DONE on Start with N=0; SHIFT->DONE when the remaining count reaches 0; DONE->IDLE unconditionally.
REQ-015 SHALL capture Operand, Type, CIn and the effective count N in the accept cycle; later input changes SHALL NOT affect the operation in flight.
REQ-016 SHALL ignore Start while Busy=1, with no queueing.
REQ-017 SHALL shift exactly one bit position per SHIFT cycle, updating Cout with the bit shifted out (ROR: bit 0, which also wraps to bit 31).
REQ-018 SHALL compute N for Imm=1 as: LSL #0 -> N=0 (pass-through, Cout=CIn); LSR #0 -> LSR #32; ASR #0 -> ASR #32; ROR #0 -> RRX (one cycle, new bit31=CIn, Cout=old bit0).
REQ-019 SHALL compute N for Imm=0 and Amount=0 as N=0 with Out=Operand and Cout=CIn for every Type.
REQ-020 SHALL, for Imm=0 with LSL/LSR/ASR and Amount>=32, use N=32 but yield LSL/LSR: Out=0 with Cout=0 when Amount>32 and Cout=shifted-out bit when Amount=32; ASR: Out=32 copies of bit31 with Cout=bit31.
REQ-021 SHALL, for Imm=0 with ROR and Amount!=0, use N=Amount[4:0]; when Amount[4:0]=0, N=0 with Out=Operand and Cout=Operand[31].
REQ-022 SHALL assert Done exactly N+1 cycles after the accept edge (latency 1 when N=0, 33 maximum).
REQ-023 SHALL allow Start in the cycle after Done (back-to-back throughput N+2 cycles).

Reset
REQ-024 SHALL, while nReset=0, immediately force state IDLE, Out=0, Cout=0, Busy=0, Done=0 and the counter to 0, independent of Clk.
REQ-025 SHALL abort any in-flight operation on reset without producing Done; the first accept after reset release SHALL behave as from power-up.

Structure
REQ-026 SHALL place the shift-type encodings (LSL/LSR/ASR/ROR) and the FSM state encoding in a shared package, shifter_pkg, reused by the decode logic.
REQ-027 SHALL isolate the one-bit combinational step (Type, data, carry in -> data, carry out) in sub-module shift_step; counter, FSM and capture registers stay in shift_sequencer.

Verification
REQ-028 SHALL cover: Imm=1, LSL #4, Operand=0x8000_000F -> Out=0x0000_00F0, Cout=0, Done 5 cycles after accept.
REQ-029 SHALL cover: Imm=1, ROR #0 (RRX), Operand=0x0000_0001, CIn=1 -> Out=0x8000_0000, Cout=1, Done after 2 cycles.
REQ-030 SHALL cover: Imm=0, ASR, Amount=40, Operand=0x8000_0000 -> Out=0xFFFF_FFFF, Cout=1, Done after 33 cycles; and LSR Amount=32, Operand=0x8000_0000 -> Out=0, Cout=1.
REQ-031 SHALL cover: Imm=0, Amount=0, any Type, CIn=1, Operand=0x1234_5678 -> Out=0x1234_5678, Cout=1, Done after 1 cycle.
REQ-032 SHALL cover: Start re-asserted while Busy=1 with different inputs -> ignored, first result unchanged; next Start in the cycle after Done is accepted.
REQ-033 SHALL cover: nReset pulsed mid-SHIFT -> outputs zero immediately, no Done pulse, and a subsequent LSR #1 of 0x2 -> Out=0x1, Cout=0.
